// File: rtl/lut_pkg.sv
// Shared width defaults, loader state encoding and the parity helper for the lut_bank slice.
package lut_pkg;

    localparam int unsigned LutAddrW = 8;
    localparam int unsigned LutDataW = 16;
    localparam int unsigned LutNumRd = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } lut_ld_state_t;

    // Even-parity bit: XOR of all data bits, so data plus parity has an even popcount.
    // Callers zero-extend entries of up to 64 bits.
    function automatic logic lut_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/lut_loader.sv
// Streaming burst loader for lut_bank: walks a contiguous, wrapping address range and
// emits one write per accepted ld_valid/ld_ready beat.
module lut_loader
    import lut_pkg::*;
#(
    parameter int unsigned ADDR_W = LutAddrW,
    parameter int unsigned DATA_W = LutDataW
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic [ADDR_W:0]   ld_count_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);

    localparam logic [ADDR_W-1:0] AddrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   RemainOne = {{ADDR_W{1'b0}}, 1'b1};

    lut_ld_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              ready_q;
    logic              done_q;
    logic              accept;

    assign accept = ld_valid_i & ready_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ld_start_i) begin
                        if (ld_count_i != '0) begin
                            state_q  <= LOAD;
                            addr_q   <= ld_base_i;
                            remain_q <= ld_count_i;
                            ready_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // addr_q is exactly ADDR_W bits wide, so it wraps modulo DEPTH.
                        addr_q   <= addr_q + AddrOne;
                        remain_q <= remain_q - RemainOne;
                        if (remain_q == RemainOne) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready_o = ready_q;
    assign ld_busy_o  = (state_q != IDLE);
    assign ld_done_o  = done_q;
    assign we_o       = accept;
    assign waddr_o    = addr_q;
    assign wdata_o    = ld_data_i;

endmodule

// File: rtl/lut_bank.sv
// Run-time writable line-target lookup table with written flags and NUM_RD registered read
// ports. Define LUT_PARITY_EN to store a per-entry even-parity bit and report rd_perr.
module lut_bank
    import lut_pkg::*;
#(
    parameter int unsigned ADDR_W = LutAddrW,
    parameter int unsigned DATA_W = LutDataW,
    parameter int unsigned NUM_RD = LutNumRd
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     ld_start_i,
    input  logic [ADDR_W-1:0]        ld_base_i,
    input  logic [ADDR_W:0]          ld_count_i,
    input  logic                     ld_valid_i,
    input  logic [DATA_W-1:0]        ld_data_i,
    output logic                     ld_ready_o,
    output logic                     ld_busy_o,
    output logic                     ld_done_o,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_valid_o,
    output logic [NUM_RD-1:0]        rd_hit_o,
    output logic [NUM_RD-1:0]        rd_perr_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    lut_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_loader (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .ld_start_i(ld_start_i),
        .ld_base_i (ld_base_i),
        .ld_count_i(ld_count_i),
        .ld_valid_i(ld_valid_i),
        .ld_data_i (ld_data_i),
        .ld_ready_o(ld_ready_o),
        .ld_busy_o (ld_busy_o),
        .ld_done_o (ld_done_o),
        .we_o      (we),
        .waddr_o   (waddr),
        .wdata_o   (wdata)
    );

    logic [DATA_W-1:0] mem_q [Depth];
    logic [Depth-1:0]  flag_q;

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // The write's flag set comes after the clear so a same-cycle write keeps its flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flag_q <= '0;
        end else begin
            if (clear_i) begin
                flag_q <= '0;
            end
            if (we) begin
                flag_q[waddr] <= 1'b1;
            end
        end
    end

`ifdef LUT_PARITY_EN
    logic [Depth-1:0] par_q;

    always_ff @(posedge clk_i) begin
        if (we) begin
            par_q[waddr] <= lut_parity(64'(wdata));
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              hit_q;

        assign addr = rd_addr_i[p*ADDR_W +: ADDR_W];

        // Array and flags are read before this edge's write/clear lands: read-before-write.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                valid_q <= 1'b0;
                hit_q   <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= rd_en_i[p];
                if (rd_en_i[p]) begin
                    data_q <= mem_q[addr];
                    hit_q  <= flag_q[addr];
                end
            end
        end

`ifdef LUT_PARITY_EN
        logic perr_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                perr_q <= 1'b0;
            end else begin
                perr_q <= rd_en_i[p] & (par_q[addr] ^ lut_parity(64'(mem_q[addr])));
            end
        end

        assign rd_perr_o[p] = perr_q;
`else
        assign rd_perr_o[p] = 1'b0;
`endif

        assign rd_data_o[p*DATA_W +: DATA_W] = data_q;
        assign rd_valid_o[p]                 = valid_q;
        assign rd_hit_o[p]                   = hit_q;
    end

endmodule

// File: doc/lut_bank.md
Name: lut_bank

Overview:
- Parametrised, run-time writable successor to the fixed program line-target lookup table.
- Holds DEPTH = 2**ADDR_W entries of DATA_W bits.
- A streaming loader fills a contiguous address range through a valid/ready handshake; NUM_RD independent lookup ports read with one-cycle registered latency.
- Each entry carries a written flag. A lookup can therefore report whether its target was ever loaded, so the fetch/branch logic can trap on uninitialised lines.

Parameters:
- ADDR_W, 8, entry address width; DEPTH = 2**ADDR_W.
- DATA_W, 16, entry width (one line target/instruction word).
- NUM_RD, 2, number of independent read ports.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  invalidate all entries (written flags to 0); array data untouched.
- ld_start  in  1  begin a load burst; honoured only in IDLE.
- ld_base  in  ADDR_W  first address of burst, sampled with ld_start.
- ld_count  in  ADDR_W+1  number of entries in burst (0..DEPTH), sampled with ld_start.
- ld_valid  in  1  loader data valid.
- ld_data  in  DATA_W  loader data word.
- ld_ready  out  1  loader accepts word this cycle.
- ld_busy  out  1  FSM not in IDLE.
- ld_done  out  1  one-cycle pulse at burst completion.
- rd_en  in  NUM_RD  per-port lookup request.
- rd_addr  in  NUM_RD*ADDR_W  packed lookup addresses, port p at [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered lookup data.
- rd_valid  out  NUM_RD  lookup result valid, one cycle after rd_en.
- rd_hit  out  NUM_RD  looked-up entry had written flag set.
- rd_perr  out  NUM_RD  parity error on lookup (see Optional Feature).

Behaviour:
- Reset values:
  - ld_ready=0, ld_busy=0, ld_done=0.
  - rd_valid=0, rd_hit=0, rd_perr=0, rd_data=0.
  - All written flags 0; FSM to IDLE.
  - Array contents not reset.
- FSM states:
  - IDLE -> LOAD on ld_start with ld_count!=0; addr_ctr<=ld_base, remain<=ld_count.
  - IDLE -> DONE on ld_start with ld_count==0 (no writes).
  - LOAD: ld_ready=1. When ld_valid&ld_ready: write ld_data at addr_ctr, set its flag, addr_ctr+1, remain-1.
  - LOAD -> DONE when the accepted word makes remain reach 0.
  - LOAD holds while ld_valid=0; no timeout.
  - DONE: ld_done=1 for exactly one cycle, ld_ready=0 -> IDLE.
  - ld_start outside IDLE ignored; ld_base/ld_count are not re-sampled.
- addr_ctr wraps modulo DEPTH. Example: base 0xFE, count 4 writes 0xFE, 0xFF, 0x00, 0x01.
- ld_count=DEPTH writes every entry exactly once.
- Reads:
  - Port p registers rd_data/rd_hit from rd_addr[p] when rd_en[p]=1; rd_valid[p]=1 next cycle.
  - rd_en[p]=0: rd_valid[p]=0 next cycle, rd_data/rd_hit hold their last value.
  - Reads permitted in every state, including during LOAD.
  - Ports are fully independent; the same address on several ports is legal.
- Read/write same address, same cycle: read-before-write. The returned data and hit are the pre-write values.
- clear:
  - Clears all flags in one cycle; legal in any state and does not affect the FSM.
  - A load write in the same cycle as clear sets its own flag (write wins).
  - A read in the same cycle as clear returns the pre-clear hit.
- reset mid-LOAD: FSM to IDLE next cycle, no ld_done, all flags cleared, already-written data retained.
- Per-cycle throughput: one load word, and NUM_RD lookups.

Optional Feature:
- Macro LUT_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from ld_data on write.
  - On lookup, rd_perr[p]=1 with rd_valid[p] when stored parity mismatches stored data.
  - rd_hit is unaffected.
- Undefined: no parity storage; rd_perr tied to 0. Port list identical in both builds.

Decomposition:
- Package lut_pkg holds:
  - Default width constants.
  - Enum lut_ld_state_t {IDLE, LOAD, DONE}.
  - Parity function.
- Sub-module lut_loader: FSM, address/remaining counters, handshake outputs. Outputs write enable, write address, write data.
- lut_bank instantiates lut_loader and owns the array, flags and read registers.

Test Plan:
- Reset then lookup port 0 at 0x10 -> rd_valid=1 one cycle later, rd_hit=0.
- Load base 0x20, count 3, words 0x1111/0x2222/0x3333 with a 2-cycle ld_valid gap after the first word -> ld_done one pulse after the third accept; reads of 0x20..0x22 return those values with rd_hit=1.
- Load base 0xFE, count 4 -> entries 0xFE, 0xFF, 0x00, 0x01 written; 0x02 still rd_hit=0.
- During LOAD, port 1 reads the address being written the same cycle (old 0x1111, new 0xAAAA) -> 0x1111; a repeat read next cycle -> 0xAAAA.
- Assert reset after 2 of 5 words -> ld_busy=0, no ld_done, all reads rd_hit=0. Then clear together with a load write to 0x05 -> only 0x05 hits afterwards.
- LUT_PARITY_EN: deposit a flipped data bit into a stored entry via hierarchical access -> rd_perr=1 with rd_valid. Without the macro -> rd_perr stays 0.
